// File: rtl/audio_regs_pkg.sv
// audio_regs_pkg
// Shared definitions for the audio register block: register byte offsets,
// the derived register index values, the AXI OKAY response code and a
// byte-strobe merge helper.
package audio_regs_pkg;

    localparam int REG_IDX_W = 2;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_DIV    = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_COUNT  = 4'hC;

    // Registers are word-aligned, so the index is offset bits [3:2].
    localparam logic [REG_IDX_W-1:0] IDX_CTRL   = OFF_CTRL[3:2];
    localparam logic [REG_IDX_W-1:0] IDX_DIV    = OFF_DIV[3:2];
    localparam logic [REG_IDX_W-1:0] IDX_STATUS = OFF_STATUS[3:2];
    localparam logic [REG_IDX_W-1:0] IDX_COUNT  = OFF_COUNT[3:2];

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sample_counter.sv
// sample_counter
// Free-running 32-bit sample counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   inc   : count one sample this cycle
//   clr   : clear to zero; wins over a same-cycle inc
//   count : current count, wraps 0xFFFFFFFF -> 0
module sample_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/audio_regs_axil_slave.sv
// audio_regs_axil_slave
// AXI4-Lite slave exposing four audio registers:
//   0x0 CTRL   RW  -> ctrl_o
//   0x4 DIV    RW  -> div_o
//   0x8 STATUS RO  <- status_i
//   0xC COUNT  RO  sample_valid_i pulse count; any write clears it
// Ports: ACLK / ARESET (sync, active high), the standard AXI-Lite AW/W/B/AR/R
// channels, ctrl_o, div_o, status_i, sample_valid_i.
// One write outstanding at a time; read and write channels run independently.
module audio_regs_axil_slave
    import audio_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     ctrl_o,
    output logic [31:0]                     div_o,
    input  logic [31:0]                     status_i,
    input  logic                            sample_valid_i
);

    logic                 aw_latched;
    logic                 w_latched;
    logic [REG_IDX_W-1:0] wr_idx;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic                 do_write;
    logic                 count_clr;
    logic [31:0]          count;
    logic [31:0]          rd_mux;

    // Byte-lane bits of the address carry no register selection.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;

    // The write commits on the edge after both halves are held, and BVALID
    // rises on that same edge.
    assign do_write  = aw_latched && w_latched;
    assign count_clr = do_write && (wr_idx == IDX_COUNT);

    // ---------------------------------------------------------------- write
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            aw_latched    <= 1'b0;
            w_latched     <= 1'b0;
            wr_idx        <= '0;
            wr_data       <= '0;
            wr_strb       <= '0;
            ctrl_o        <= '0;
            div_o         <= '0;
        end else begin
            // Single-cycle READY pulses; held off while a response is pending.
            S_AXI_AWREADY <= S_AXI_AWVALID && !S_AXI_AWREADY && !aw_latched && !S_AXI_BVALID;
            S_AXI_WREADY  <= S_AXI_WVALID  && !S_AXI_WREADY  && !w_latched  && !S_AXI_BVALID;

            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_latched <= 1'b1;
                wr_idx     <= S_AXI_AWADDR[3:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_latched <= 1'b1;
                wr_data   <= S_AXI_WDATA;
                wr_strb   <= S_AXI_WSTRB;
            end

            if (do_write) begin
                aw_latched   <= 1'b0;
                w_latched    <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                case (wr_idx)
                    IDX_CTRL: ctrl_o <= apply_strb(ctrl_o, wr_data, wr_strb);
                    IDX_DIV:  div_o  <= apply_strb(div_o,  wr_data, wr_strb);
                    default:  ;  // STATUS ignored, COUNT cleared via count_clr
                endcase
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- read
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            IDX_CTRL:   rd_mux = ctrl_o;
            IDX_DIV:    rd_mux = div_o;
            IDX_STATUS: rd_mux = status_i;
            IDX_COUNT:  rd_mux = count;
            default:    rd_mux = '0;
        endcase
    end

    // RDATA is captured on the accept edge, so a same-edge write is not seen.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    sample_counter u_sample_counter (
        .clk   (ACLK),
        .rst   (ARESET),
        .inc   (sample_valid_i),
        .clr   (count_clr),
        .count (count)
    );

endmodule

// File: tb/tb_audio_regs_axil_slave.sv
// tb_audio_regs_axil_slave
// Directed bench for audio_regs_axil_slave. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_audio_regs_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] ctrl_o;
    logic [31:0] div_o;
    logic [31:0] status_i;
    logic        sample_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    audio_regs_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK           (clk),
        .ARESET         (rst),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready),
        .ctrl_o         (ctrl_o),
        .div_o          (div_o),
        .status_i       (status_i),
        .sample_valid_i (sample_valid)
    );

    // Bus write. take_b=0 leaves the response pending (BREADY low).
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit take_b,
                             output logic [1:0] resp);
        bit aw_done, w_done, got_b, a_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; got_b = 0; resp = 2'b11;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = take_b;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(posedge clk); #1;
            if (a_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1; end
            n++;
        end
        n = 0;
        while (aw_done && w_done && !got_b && n < 20) begin
            @(negedge clk);
            if (bvalid) begin got_b = 1; resp = bresp; end
            if (!got_b || take_b) begin @(posedge clk); #1; end
            n++;
        end
        if (take_b) bready = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (!(aw_done && w_done && got_b)) begin
            errors++;
            $display("FAIL write_timeout addr=%h aw=%0d w=%0d b=%0d expected all 1", addr, aw_done, w_done, got_b);
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_done, got_r, hs;
        int n;
        ar_done = 0; got_r = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!ar_done && n < 20) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) begin arvalid = 1'b0; ar_done = 1; end
            n++;
        end
        n = 0;
        while (ar_done && !got_r && n < 20) begin
            @(negedge clk);
            if (rvalid) begin got_r = 1; data = rdata; resp = rresp; end
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b0; arvalid = 1'b0;
        checks++;
        if (!(ar_done && got_r)) begin
            errors++;
            $display("FAIL read_timeout addr=%h ar=%0d r=%0d expected both 1", addr, ar_done, got_r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake got=%b expected=00000", {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if ({rdata, bresp, rresp} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data rdata=%h bresp=%b rresp=%b expected 0", rdata, bresp, rresp);
        end
        checks++;
        if (ctrl_o !== 32'h0 || div_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs ctrl=%h div=%h expected 0", ctrl_o, div_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_all();
        logic [1:0] r;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, 1'b1, r);
            checks++;
            if (r !== 2'b00) begin
                errors++;
                $display("FAIL write_bresp idx=%0d got=%b expected=00", i, r);
            end
        end
        checks++;
        if (ctrl_o !== 32'h1 || div_o !== 32'h2) begin
            errors++;
            $display("FAIL write_outputs ctrl=%h div=%h expected 1/2", ctrl_o, div_o);
        end
    endtask

    task automatic test_read_all();
        logic [31:0] exp_v [5];
        logic [3:0]  adr   [5];
        logic [31:0] d;
        logic [1:0]  r;
        status_i = 32'hA5A5_0003;
        exp_v = '{32'h1, 32'h2, 32'hA5A5_0003, 32'h0, 32'h2};
        adr   = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h5};  // 0x5 checks low bits ignored
        for (int i = 0; i < 5; i++) begin
            axi_read(adr[i], d, r);
            checks++;
            if (d !== exp_v[i] || r !== 2'b00) begin
                errors++;
                $display("FAIL read_reg addr=%h got=%h/%b expected=%h/00", adr[i], d, r, exp_v[i]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r;
        axi_write(4'h0, 32'h0, 4'hF, 1'b1, r);
        axi_write(4'h0, 32'hFFFF_FFFF, 4'h2, 1'b1, r);
        checks++;
        if (ctrl_o !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL strobe_ctrl got=%h expected=0000ff00", ctrl_o);
        end
    endtask

    task automatic test_w_before_aw();
        bit done, hs;
        int n;
        @(posedge clk); #1;
        wdata = 32'h0000_1234; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        done = 0; n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            hs = wvalid && wready;
            @(posedge clk); #1;
            if (hs) begin wvalid = 1'b0; done = 1; end
            n++;
        end
        @(negedge clk);
        checks++;
        if (!done || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_no_b w_done=%0d bvalid=%b expected 1/0", done, bvalid);
        end
        @(posedge clk); #1;
        awaddr = 4'h0; awvalid = 1'b1;
        done = 0; n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            hs = awvalid && awready;
            @(posedge clk); #1;
            if (hs) begin awvalid = 1'b0; done = 1; end
            n++;
        end
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        // Second write address offered while the response is held.
        awaddr = 4'h4; awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cyc=%0d bvalid=%b awready=%b expected 1/0", c, bvalid, awready);
            end
            @(posedge clk); #1;
        end
        awvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || ctrl_o !== 32'h0000_1234 || div_o !== 32'h2) begin
            errors++;
            $display("FAIL wfirst_result bvalid=%b ctrl=%h div=%h expected 0/00001234/00000002", bvalid, ctrl_o, div_o);
        end
    endtask

    task automatic test_count();
        logic [31:0] d;
        logic [1:0]  r;
        @(posedge clk); #1;
        sample_valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        sample_valid = 1'b0;
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'd10) begin
            errors++;
            $display("FAIL count_ten got=%0d expected=10", d);
        end
        // Clear write lands on the same edge as a sample pulse.
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'h0; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;           // READYs rise
        @(posedge clk); #1;           // both halves accepted
        awvalid = 1'b0; wvalid = 1'b0; sample_valid = 1'b1;
        @(posedge clk); #1;           // commit edge
        sample_valid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL count_clr_bvalid got=%b expected=1", bvalid);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL count_clr_vs_inc got=%0d expected=0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h0, 32'h77, 4'hF, 1'b0, r);
        checks++;
        if (bvalid !== 1'b1 || ctrl_o !== 32'h77) begin
            errors++;
            $display("FAIL pre_reset bvalid=%b ctrl=%h expected 1/00000077", bvalid, ctrl_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || ctrl_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset bvalid=%b ctrl=%h expected 0/0", bvalid, ctrl_o);
        end
        axi_write(4'h4, 32'h55, 4'hF, 1'b1, r);
        checks++;
        if (r !== 2'b00 || div_o !== 32'h55) begin
            errors++;
            $display("FAIL post_reset_write resp=%b div=%h expected 00/00000055", r, div_o);
        end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h55 || r !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_read got=%h/%b expected=00000055/00", d, r);
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        status_i = '0; sample_valid = 1'b0;
        test_reset();
        test_write_all();
        test_read_all();
        test_strobe();
        test_w_before_aw();
        test_count();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_regs_axil_slave.md
AUDIO_REGS_AXIL_SLAVE -- requirements
Module: audio_regs_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width.
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port S_AXI_AWADDR  in  ADDR_WIDTH  write address.
REQ-006 SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-007 SHALL have port S_AXI_AWREADY  out  1  write address accepted.
REQ-008 SHALL have port S_AXI_WDATA  in  32  write data.
REQ-009 SHALL have port S_AXI_WSTRB  in  4  byte lane enables.
REQ-010 SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-011 SHALL have port S_AXI_WREADY  out  1  write data accepted.
REQ-012 SHALL have port S_AXI_BRESP  out  2  write response (always OKAY, 2'b00).
REQ-013 SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-014 SHALL have port S_AXI_BREADY  in  1  master accepts response.
REQ-015 SHALL have port S_AXI_ARADDR  in  ADDR_WIDTH  read address.
REQ-016 SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-017 SHALL have port S_AXI_ARREADY  out  1  read address accepted.
REQ-018 SHALL have port S_AXI_RDATA  out  32  read data.
REQ-019 SHALL have port S_AXI_RRESP  out  2  read response (always OKAY).
REQ-020 SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-021 SHALL have port S_AXI_RREADY  in  1  master accepts read data.
REQ-022 SHALL have ports ctrl_o out 32 (reg 0x0), div_o out 32 (reg 0x4), status_i in 32, sample_valid_i in 1 (one-cycle sample pulse).

Function
REQ-023 SHALL decode register index from addr[3:2], ignoring addr[1:0]: 0x0 CTRL RW, 0x4 DIV RW, 0x8 STATUS RO (=status_i), 0xC COUNT RO.
REQ-024 SHALL accept AW and W independently; each READY asserts for exactly one cycle when its VALID is high, no address/data is latched, and BVALID is low.
REQ-025 SHALL perform the register write in the cycle after both address and data are latched (same-cycle or any order), and SHALL assert BVALID in that same cycle.
REQ-026 SHALL hold BVALID until BREADY; SHALL stall AWREADY/WREADY while BVALID is high (one outstanding write).
REQ-027 SHALL apply WSTRB per byte on CTRL/DIV; writes to STATUS are ignored; any write to COUNT (any strobe) clears it to 0.
REQ-028 SHALL assert ARREADY for one cycle when ARVALID is high and RVALID is low, then assert RVALID with RDATA on the next cycle, holding both until RREADY.
REQ-029 SHALL sample STATUS into RDATA at the address-accept cycle.
REQ-030 COUNT SHALL increment by 1 per sample_valid_i cycle and wrap 0xFFFFFFFF->0; a same-cycle clear and increment SHALL yield 0.
REQ-031 SHALL process read and write channels concurrently; a read of a register written in the same cycle SHALL return the pre-write value.

Reset
REQ-032 On ARESET all READY/VALID outputs SHALL be 0, RDATA/BRESP/RRESP 0, CTRL/DIV/COUNT 0, latched flags cleared.
REQ-033 Reset mid-transaction SHALL abort it without a response; the first post-reset transaction SHALL complete normally.

Structure
REQ-034 Register offsets, index width and RESP_OKAY SHALL live in shared package audio_regs_pkg.
REQ-035 Read and write paths SHALL stay in this module; the COUNT counter SHALL be sub-module sample_counter (inc, clr, count).

Verification
REQ-036 Write 1,2,3,4 to 0x0,0x4,0x8,0xC (WSTRB=0xF) -> each BRESP=OKAY; ctrl_o=1, div_o=2; COUNT=0.
REQ-037 status_i=0xA5A5_0003, read 0x0..0xC -> 0x1, 0x2, 0xA5A5_0003, 0x0, all RRESP OKAY.
REQ-038 W presented 3 cycles before AW, BREADY held low 5 cycles -> single write, BVALID held, no second AWREADY until B handshake.
REQ-039 Write 0xFFFF_FFFF to CTRL with WSTRB=0x2 after CTRL=0 -> CTRL=0x0000_FF00.
REQ-040 10 sample_valid_i pulses -> COUNT reads 10; write COUNT coincident with a pulse -> COUNT=0.
REQ-041 Assert ARESET while BVALID pending -> BVALID=0, ctrl_o=0 next cycle; subsequent write/read of DIV=0x55 succeeds.
